instr_mem_bank: RTL and testbench
=================================

INSTR_MEM_BANK -- requirements
Module: instr_mem_bank

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-002 SHALL have parameter LANE_W, default 8, bits per byte lane.
REQ-003 SHALL have parameter NUM_LANES, default 4, lanes per word (power of two, >=2).
REQ-004 SHALL have parameter DEPTH_WORDS, default 1024, words stored.
REQ-005 SHALL have parameter RD_LATENCY, default 2, accept-to-response cycles, legal 1..4.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-008 SHALL have port req_valid  input  1  request present.
REQ-009 SHALL have port req_ready  output  1  request may be accepted.
REQ-010 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-011 SHALL have port req_we  input  1  1=write, 0=read.
REQ-012 SHALL have port req_wstrb  input  NUM_LANES  per-lane write enable.
REQ-013 SHALL have port req_wdata  input  NUM_LANES*LANE_W  write data, lane 0 in LSBs.
REQ-014 SHALL have port rsp_valid  output  1  response present.
REQ-015 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-016 SHALL have port rsp_rdata  output  NUM_LANES*LANE_W  read data, lane 0 in LSBs.
REQ-017 SHALL have port rsp_err  output  1  misaligned or out-of-range access.

Function
REQ-018 SHALL accept a request on a rising edge where req_valid and req_ready are both 1; at most one per cycle.
REQ-019 SHALL form word index = req_addr[ADDR_W-1:log2(NUM_LANES)].
REQ-020 SHALL flag error when req_addr low log2(NUM_LANES) bits nonzero or index >= DEPTH_WORDS; errored request: no array write, rsp_rdata=0, rsp_err=1.
REQ-021 SHALL on accepted valid write update only lanes with req_wstrb[i]=1 at the accepting edge; wstrb=0 writes nothing, still responds.
REQ-022 SHALL return exactly one response per accepted request, in acceptance order; write responses carry rsp_rdata=0, rsp_err per REQ-020.
REQ-023 SHALL sample read data at the accepting edge, so a read accepted the cycle after a write to the same word returns the new data.
REQ-024 SHALL pass responses through a RD_LATENCY-stage valid pipeline into an in-order response FIFO of depth RD_LATENCY+1; earliest rsp_valid is RD_LATENCY cycles after the accepting edge.
REQ-025 SHALL keep an outstanding counter (pipeline + FIFO occupancy): +1 on accept, -1 on rsp_valid&&rsp_ready, unchanged when both occur in one cycle.
REQ-026 SHALL drive req_ready = (outstanding < RD_LATENCY+1) combinationally from registered state; never overflow the FIFO.
REQ-027 SHALL hold rsp_valid, rsp_rdata, rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-028 SHALL, when FIFO empty and a response exits the pipeline with rsp_ready=1, still present it for at least one cycle (no combinational pass-through from req to rsp).

Reset
REQ-029 SHALL on resetn=0 immediately clear pipeline valid bits, FIFO pointers and outstanding counter; rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 after release.
REQ-030 SHALL drop in-flight requests on reset mid-operation; writes already committed remain; array contents are not reset.

Configuration
REQ-031 SHALL support macro INSTR_MEM_PARITY_EN; undefined: no parity storage, ports of REQ-032 absent.
REQ-032 SHALL, with INSTR_MEM_PARITY_EN defined, add ports err_inject  input  NUM_LANES  flip stored parity bit of that lane on write, and rsp_parity_err  output  1  parity mismatch, reset 0.
REQ-033 SHALL, with INSTR_MEM_PARITY_EN, store one even-parity bit per lane on write and set rsp_parity_err = OR of per-lane mismatches on read responses; 0 on write/errored responses; data still returned.

Verification
REQ-034 SHALL cover: write 0xDEADBEEF wstrb=0xF addr 0x10, then read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 2 cycles after read accept.
REQ-035 SHALL cover: after REQ-034, write 0x000000AA wstrb=0x1 addr 0x10, read 0x10 -> 0xDEADBEAA.
REQ-036 SHALL cover: read addr 0x12 and read addr 0x1000 (index 1024) -> rsp_err=1, rsp_rdata=0; write to 0x1000 leaves word 0 unchanged.
REQ-037 SHALL cover: rsp_ready=0, issue back-to-back reads -> exactly 3 accepted then req_ready=0; rsp_ready=1 -> 3 responses in order, req_ready returns to 1.
REQ-038 SHALL cover: resetn pulsed low with 2 outstanding reads -> rsp_valid=0 same cycle, no stale responses after release, prior written data intact.
REQ-039 SHALL cover (INSTR_MEM_PARITY_EN): write 0x01020304 err_inject=0x2 addr 0x20, read 0x20 -> rsp_rdata=0x01020304, rsp_parity_err=1; rewrite with err_inject=0 -> rsp_parity_err=0.

Source files
------------

// File: rtl/instr_mem_bank.sv
// instr_mem_bank
//   Single-port, byte-lane-writable instruction/data memory bank. Requests are
//   accepted with a valid/ready handshake. Each accepted request produces one
//   in-order response after a fixed RD_LATENCY-stage pipeline. The response
//   then drains through a small FIFO, so backpressure on the response side
//   never drops data.
//
//   Optional feature macro: INSTR_MEM_PARITY_EN
//     When defined, the bank stores one even-parity bit per lane. It adds the
//     ports err_inject and rsp_parity_err.
//
// Ports
//   clk            sole clock, rising edge
//   resetn         asynchronous active-low reset
//   req_valid      request present
//   req_ready      request may be accepted this cycle
//   req_addr       byte address (word index = upper bits, low bits must be 0)
//   req_we         1 = write, 0 = read
//   req_wstrb      per-lane write enable
//   req_wdata      write data, lane 0 in LSBs
//   rsp_valid      response present
//   rsp_ready      consumer takes response
//   rsp_rdata      read data (0 for writes and errored requests)
//   rsp_err        misaligned or out-of-range access
//   err_inject     (parity build) flip stored parity of a lane on write
//   rsp_parity_err (parity build) stored parity mismatch on a read response
module instr_mem_bank #(
    parameter int ADDR_W      = 32,
    parameter int LANE_W      = 8,
    parameter int NUM_LANES   = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int RD_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic                          req_we,
    input  logic [NUM_LANES-1:0]          req_wstrb,
    input  logic [NUM_LANES*LANE_W-1:0]   req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [NUM_LANES*LANE_W-1:0]   rsp_rdata,
    output logic                          rsp_err
`ifdef INSTR_MEM_PARITY_EN
    ,
    input  logic [NUM_LANES-1:0]          err_inject,
    output logic                          rsp_parity_err
`endif
);

    localparam int DATA_W = NUM_LANES * LANE_W;
    localparam int OFF_W  = $clog2(NUM_LANES);
    localparam int IDX_W  = ADDR_W - OFF_W;
    localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int FIFO_D = RD_LATENCY + 1;
    localparam int PTR_W  = $clog2(FIFO_D);
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam int LAST   = RD_LATENCY - 1;

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    logic              r_pv [RD_LATENCY];
    logic [DATA_W-1:0] r_pd [RD_LATENCY];
    logic              r_pe [RD_LATENCY];

    logic [DATA_W-1:0] r_fd [FIFO_D];
    logic              r_fe [FIFO_D];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_fcnt;
    logic [CNT_W-1:0]  r_out;

    logic [IDX_W-1:0]  w_idx;
    logic [MEM_AW-1:0] w_midx;
    logic              w_err;
    logic              w_acc;
    logic              w_rd_ok;
    logic              w_push;
    logic              w_pop;

    assign w_idx   = req_addr[ADDR_W-1:OFF_W];
    assign w_midx  = w_idx[MEM_AW-1:0];
    assign w_err   = (|req_addr[OFF_W-1:0]) || (w_idx >= IDX_W'(DEPTH_WORDS));
    assign w_acc   = req_valid && req_ready;
    assign w_rd_ok = w_acc && !req_we && !w_err;

    // Outstanding count covers both the pipeline and the FIFO, so limiting it
    // to the FIFO depth guarantees every pipelined response has a slot.
    assign req_ready = (r_out < CNT_W'(FIFO_D));

    assign w_push    = r_pv[LAST];
    assign rsp_valid = (r_fcnt != '0);
    assign w_pop     = rsp_valid && rsp_ready;

    // Outputs are forced to zero when empty so the reset/idle state is clean.
    assign rsp_rdata = rsp_valid ? r_fd[r_rptr] : '0;
    assign rsp_err   = rsp_valid ? r_fe[r_rptr] : 1'b0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
    endfunction

    // Array is intentionally not reset; committed writes survive a reset.
    always_ff @(posedge clk) begin
        if (w_acc && req_we && !w_err) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (req_wstrb[i])
                    r_mem[w_midx][i*LANE_W +: LANE_W] <= req_wdata[i*LANE_W +: LANE_W];
            end
        end
    end

    // Read data is captured at the accepting edge, after any write committed
    // on the previous edge, so read-after-write returns the new data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_pd[i] <= '0;
                r_pe[i] <= 1'b0;
            end
        end else begin
            r_pv[0] <= w_acc;
            r_pd[0] <= w_rd_ok ? r_mem[w_midx] : '0;
            r_pe[0] <= w_acc && w_err;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fd[r_wptr] <= r_pd[LAST];
            r_fe[r_wptr] <= r_pe[LAST];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
            r_out  <= '0;
        end else begin
            if (w_push) r_wptr <= ptr_inc(r_wptr);
            if (w_pop)  r_rptr <= ptr_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + 1'b1;
                2'b01:   r_fcnt <= r_fcnt - 1'b1;
                default: r_fcnt <= r_fcnt;
            endcase
            case ({w_acc, w_pop})
                2'b10:   r_out <= r_out + 1'b1;
                2'b01:   r_out <= r_out - 1'b1;
                default: r_out <= r_out;
            endcase
        end
    end

`ifdef INSTR_MEM_PARITY_EN
    logic [NUM_LANES-1:0] r_par [DEPTH_WORDS];
    logic                 r_pp  [RD_LATENCY];
    logic                 r_fp  [FIFO_D];
    logic                 w_perr;

    always_comb begin
        w_perr = 1'b0;
        for (int i = 0; i < NUM_LANES; i++)
            w_perr = w_perr | ((^r_mem[w_midx][i*LANE_W +: LANE_W]) ^ r_par[w_midx][i]);
    end

    always_ff @(posedge clk) begin
        if (w_acc && req_we && !w_err) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (req_wstrb[i])
                    r_par[w_midx][i] <= (^req_wdata[i*LANE_W +: LANE_W]) ^ err_inject[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < RD_LATENCY; i++) r_pp[i] <= 1'b0;
        end else begin
            r_pp[0] <= w_rd_ok && w_perr;
            for (int i = 1; i < RD_LATENCY; i++) r_pp[i] <= r_pp[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fp[r_wptr] <= r_pp[LAST];
    end

    assign rsp_parity_err = rsp_valid ? r_fp[r_rptr] : 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_bank.sv
module tb_instr_mem_bank;

    localparam int LAT = 2;
    localparam int OUTST_MAX = LAT + 1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef INSTR_MEM_PARITY_EN
    logic [3:0]  err_inject;
    logic        rsp_parity_err;
`endif

    instr_mem_bank #(
        .ADDR_W(32), .LANE_W(8), .NUM_LANES(4), .DEPTH_WORDS(1024), .RD_LATENCY(LAT)
    ) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef INSTR_MEM_PARITY_EN
        , .err_inject(err_inject), .rsp_parity_err(rsp_parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
        logic        p;
    } exp_t;

    exp_t     exp_q[$];
    bit [31:0] mdl_mem [1024];
    bit [3:0]  mdl_inj [1024];
    int        n_tests = 0;
    int        n_fail  = 0;
    int        n_rsp   = 0;
    bit        rand_rdy = 1'b0;
    bit        mdl_ready;

    function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endfunction

    // Reference model: word-addressed array updated lane by lane at acceptance.
    function automatic void model_accept();
        int   idx;
        exp_t e;
        idx = int'(req_addr[31:2]);
        e.d = '0; e.e = 1'b0; e.p = 1'b0;
        if (req_addr[1:0] != 2'b00 || idx >= 1024) begin
            e.e = 1'b1;
        end else if (req_we) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) begin
                    mdl_mem[idx][i*8 +: 8] = req_wdata[i*8 +: 8];
`ifdef INSTR_MEM_PARITY_EN
                    mdl_inj[idx][i] = err_inject[i];
`endif
                end
            end
        end else begin
            e.d = mdl_mem[idx];
            e.p = |mdl_inj[idx];
        end
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
        end else begin
            mdl_ready = (exp_q.size() < OUTST_MAX);
            chk("req_ready", req_ready, mdl_ready);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stale_rsp", rsp_valid, 1'b0);
                end else begin
                    chk("rsp_rdata", rsp_rdata, exp_q[0].d);
                    chk("rsp_err", rsp_err, exp_q[0].e);
`ifdef INSTR_MEM_PARITY_EN
                    chk("rsp_parity_err", rsp_parity_err, exp_q[0].p);
`endif
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        n_rsp++;
                    end
                end
            end
            if (req_valid && mdl_ready) model_accept();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_req(input bit we, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [31:0] data);
        int b;
        b = 50;
        req_valid = 1'b1; req_we = we; req_addr = addr;
        req_wstrb = strb; req_wdata = data;
        while (!req_ready && b > 0) begin tick(); b--; end
        if (b == 0) chk("req_accept_timeout", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 200;
        while (exp_q.size() != 0 && b > 0) begin tick(); b--; end
        chk("drain_done", exp_q.size(), 0);
    endtask

    task automatic wait_rsp();
        int b;
        b = 10;
        while (!rsp_valid && b > 0) begin tick(); b--; end
        chk("rsp_wait", rsp_valid, 1'b1);
    endtask

    task automatic read_expect(input logic [31:0] addr, input logic [31:0] exp_d,
                               input logic exp_e, input string tag);
        drain();
        do_req(1'b0, addr, 4'h0, 32'h0);
        wait_rsp();
        chk(tag, rsp_rdata, exp_d);
        chk({tag, "_err"}, rsp_err, exp_e);
        tick();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int snap;
        logic [31:0] a;
        int r;

        resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = 1'b0;
        req_wstrb = '0; req_wdata = '0; rsp_ready = 1'b1;
`ifdef INSTR_MEM_PARITY_EN
        err_inject = '0;
`endif
        tick(); tick();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        resetn = 1'b1;
        tick();
        chk("rel_rsp_valid", rsp_valid, 1'b0);
        chk("rel_req_ready", req_ready, 1'b1);

        // Preload a 16-word window so later reads see defined data.
        do_req(1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
        for (int i = 1; i < 16; i++) do_req(1'b1, 32'(i * 4), 4'hF, $urandom());
        drain();

        // Full write then read with latency check.
        do_req(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        drain();
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        chk("lat0_valid", rsp_valid, 1'b0);
        tick();
        chk("lat1_valid", rsp_valid, 1'b0);
        tick();
        chk("lat2_valid", rsp_valid, 1'b1);
        chk("rd_deadbeef", rsp_rdata, 32'hDEADBEEF);
        chk("rd_deadbeef_err", rsp_err, 1'b0);
        tick();

        // Single-lane write.
        do_req(1'b1, 32'h10, 4'h1, 32'h000000AA);
        read_expect(32'h10, 32'hDEADBEAA, 1'b0, "rd_strb1");

        // Strobe zero writes nothing.
        do_req(1'b1, 32'h10, 4'h0, 32'h11223344);
        read_expect(32'h10, 32'hDEADBEAA, 1'b0, "rd_strb0");

        // Error cases.
        read_expect(32'h12, 32'h0, 1'b1, "rd_misaligned");
        read_expect(32'h1000, 32'h0, 1'b1, "rd_out_of_range");
        read_expect(32'hFFC, 32'hCAFEF00D & 32'h0 | mdl_mem[1023], 1'b0, "rd_last_word");
        do_req(1'b1, 32'h1000, 4'hF, 32'h12345678);
        read_expect(32'h0, 32'hCAFEF00D, 1'b0, "rd_word0_intact");

        // Backpressure: exactly the FIFO depth is accepted.
        drain();
        rsp_ready = 1'b0;
        acc = 0;
        req_valid = 1'b1; req_we = 1'b0; req_wstrb = '0; req_wdata = '0;
        for (int k = 0; k < 8; k++) begin
            req_addr = 32'(acc * 4);
            if (req_ready) acc++;
            tick();
        end
        req_valid = 1'b0;
        chk("bp_accepted", acc, OUTST_MAX);
        chk("bp_req_ready_low", req_ready, 1'b0);
        snap = n_rsp;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("bp_rsp_count", n_rsp - snap, OUTST_MAX);
        chk("bp_req_ready_back", req_ready, 1'b1);

        // Reset with two reads in flight.
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h0, 4'h0, 32'h0);
        do_req(1'b0, 32'h10, 4'h0, 32'h0);
        tick(); tick(); tick();
        chk("pre_rst_valid", rsp_valid, 1'b1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", rsp_valid, 1'b0);
        chk("mid_rst_rdata", rsp_rdata, 32'h0);
        chk("mid_rst_req_ready", req_ready, 1'b1);
        tick(); tick();
        resetn = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        read_expect(32'h0, 32'hCAFEF00D, 1'b0, "post_rst_word0");
        read_expect(32'h10, 32'hDEADBEAA, 1'b0, "post_rst_word4");

`ifdef INSTR_MEM_PARITY_EN
        err_inject = 4'h2;
        do_req(1'b1, 32'h20, 4'hF, 32'h01020304);
        err_inject = 4'h0;
        drain();
        do_req(1'b0, 32'h20, 4'h0, 32'h0);
        wait_rsp();
        chk("par_inj_data", rsp_rdata, 32'h01020304);
        chk("par_inj_flag", rsp_parity_err, 1'b1);
        tick();
        do_req(1'b1, 32'h20, 4'hF, 32'h01020304);
        drain();
        do_req(1'b0, 32'h20, 4'h0, 32'h0);
        wait_rsp();
        chk("par_clean_data", rsp_rdata, 32'h01020304);
        chk("par_clean_flag", rsp_parity_err, 1'b0);
        tick();
`endif

        // Randomized traffic with random response backpressure.
        drain();
        rand_rdy = 1'b1;
        for (int n = 0; n < 300; n++) begin
            r = int'($urandom_range(0, 15));
            a = 32'($urandom_range(0, 15)) << 2;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            else if (r == 1) a = a + 32'h1000;
`ifdef INSTR_MEM_PARITY_EN
            err_inject = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'h0;
`endif
            do_req(1'($urandom_range(0, 1)), a, 4'($urandom()), $urandom());
            if ($urandom_range(0, 3) == 0) tick();
        end
        rand_rdy = 1'b0;
        rsp_ready = 1'b1;
        drain();
        chk("final_idle_ready", req_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
